// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl: sequences CSR instructions, ECALL and MRET onto a 4-entry
// CSR file (mstatus=0, mtvec=1, mepc=2, mcause=3) with one read port and one
// write port. A trap's CSR writes are serialised over consecutive cycles.
// Optional feature macro: CSR_TRAP_CTRL_MSTATUS_EN adds a STATUS state that
// updates MIE/MPIE/MPP in mstatus on ECALL and MRET.
module csr_trap_ctrl #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_csr_addr,
    input  logic [DATA_W-1:0] req_src,
    input  logic              req_src_is_x0,
    input  logic [DATA_W-1:0] req_pc,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_illegal,
    output logic              resp_redirect,
    output logic [DATA_W-1:0] resp_pc,
    output logic [1:0]        csr_read_idx,
    input  logic [DATA_W-1:0] csr_read_data,
    output logic              csr_write_en,
    output logic [1:0]        csr_write_idx,
    output logic [DATA_W-1:0] csr_write_data
);

    localparam logic [2:0] OP_CSRRW = 3'd0;
    localparam logic [2:0] OP_CSRRS = 3'd1;
    localparam logic [2:0] OP_CSRRC = 3'd2;
    localparam logic [2:0] OP_ECALL = 3'd3;
    localparam logic [2:0] OP_MRET  = 3'd4;

    localparam logic [1:0] IDX_MSTATUS = 2'd0;
    localparam logic [1:0] IDX_MTVEC   = 2'd1;
    localparam logic [1:0] IDX_MEPC    = 2'd2;
    localparam logic [1:0] IDX_MCAUSE  = 2'd3;

    localparam logic [DATA_W-1:0] CAUSE_ECALL_M = DATA_W'(11);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CSR,
        S_EPC,
        S_CAUSE,
        S_MRET,
`ifdef CSR_TRAP_CTRL_MSTATUS_EN
        S_STATUS,
`endif
        S_RESP
    } state_t;

    state_t state_q, state_d;

    // Captured request and registered response.
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] src_q;
    logic              src_is_x0_q;
    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] resp_rdata_q;
    logic              resp_illegal_q;
    logic              resp_redirect_q;
    logic [DATA_W-1:0] resp_pc_q;

    // Datapath load strobes from the FSM.
    logic capture, ld_csr, ld_pc, ld_illegal_op, clr_resp;

    logic       addr_known;
    logic [1:0] addr_idx;

    // Decode the captured CSR address into a file index.
    always_comb begin
        addr_known = 1'b1;
        addr_idx   = IDX_MSTATUS;
        case (addr_q)
            ADDR_W'(12'h300): addr_idx = IDX_MSTATUS;
            ADDR_W'(12'h305): addr_idx = IDX_MTVEC;
            ADDR_W'(12'h341): addr_idx = IDX_MEPC;
            ADDR_W'(12'h342): addr_idx = IDX_MCAUSE;
            default:          addr_known = 1'b0;
        endcase
    end

`ifdef CSR_TRAP_CTRL_MSTATUS_EN
    localparam int MIE_BIT  = 3;
    localparam int MPIE_BIT = 7;
    logic [DATA_W-1:0] mstatus_new;

    // Trap entry stacks MIE into MPIE and enters M-mode; MRET unstacks to U-mode.
    always_comb begin
        mstatus_new = csr_read_data;
        if (op_q == OP_ECALL) begin
            mstatus_new[MPIE_BIT] = csr_read_data[MIE_BIT];
            mstatus_new[MIE_BIT]  = 1'b0;
            mstatus_new[12:11]    = 2'b11;
        end else begin
            mstatus_new[MIE_BIT]  = csr_read_data[MPIE_BIT];
            mstatus_new[MPIE_BIT] = 1'b1;
            mstatus_new[12:11]    = 2'b00;
        end
    end
`endif

    // State register; async reset drops csr_write_en at once since it decodes state.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic and CSR file port control.
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves a value
        // unassigned and no latch is inferred.
        state_d        = state_q;
        req_ready      = 1'b0;
        resp_valid     = 1'b0;
        csr_read_idx   = 2'd0;
        csr_write_en   = 1'b0;
        csr_write_idx  = 2'd0;
        csr_write_data = '0;
        capture        = 1'b0;
        ld_csr         = 1'b0;
        ld_pc          = 1'b0;
        ld_illegal_op  = 1'b0;
        clr_resp       = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    capture = 1'b1;
                    case (req_op)
                        OP_CSRRW, OP_CSRRS, OP_CSRRC: state_d = S_CSR;
                        OP_ECALL:                     state_d = S_EPC;
                        OP_MRET:                      state_d = S_MRET;
                        default: begin
                            state_d       = S_RESP;
                            ld_illegal_op = 1'b1;
                        end
                    endcase
                end
            end
            S_CSR: begin
                ld_csr  = 1'b1;
                state_d = S_RESP;
                if (addr_known) begin
                    csr_read_idx  = addr_idx;
                    csr_write_idx = addr_idx;
                    // Set/clear with rs1=x0 is a pure read.
                    csr_write_en  = (op_q == OP_CSRRW) || !src_is_x0_q;
                    case (op_q)
                        OP_CSRRS: csr_write_data = csr_read_data | src_q;
                        OP_CSRRC: csr_write_data = csr_read_data & ~src_q;
                        default:  csr_write_data = src_q;
                    endcase
                end
            end
            S_EPC: begin
                csr_write_en   = 1'b1;
                csr_write_idx  = IDX_MEPC;
                csr_write_data = pc_q;
                state_d        = S_CAUSE;
            end
            S_CAUSE: begin
                csr_write_en   = 1'b1;
                csr_write_idx  = IDX_MCAUSE;
                csr_write_data = CAUSE_ECALL_M;
                csr_read_idx   = IDX_MTVEC;
                ld_pc          = 1'b1;
`ifdef CSR_TRAP_CTRL_MSTATUS_EN
                state_d        = S_STATUS;
`else
                state_d        = S_RESP;
`endif
            end
            S_MRET: begin
                csr_read_idx = IDX_MEPC;
                ld_pc        = 1'b1;
`ifdef CSR_TRAP_CTRL_MSTATUS_EN
                state_d      = S_STATUS;
`else
                state_d      = S_RESP;
`endif
            end
`ifdef CSR_TRAP_CTRL_MSTATUS_EN
            S_STATUS: begin
                csr_read_idx   = IDX_MSTATUS;
                csr_write_en   = 1'b1;
                csr_write_idx  = IDX_MSTATUS;
                csr_write_data = mstatus_new;
                state_d        = S_RESP;
            end
`endif
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    clr_resp = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Request capture and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q            <= '0;
            addr_q          <= '0;
            src_q           <= '0;
            src_is_x0_q     <= 1'b0;
            pc_q            <= '0;
            resp_rdata_q    <= '0;
            resp_illegal_q  <= 1'b0;
            resp_redirect_q <= 1'b0;
            resp_pc_q       <= '0;
        end else begin
            if (capture) begin
                op_q        <= req_op;
                addr_q      <= req_csr_addr;
                src_q       <= req_src;
                src_is_x0_q <= req_src_is_x0;
                pc_q        <= req_pc;
            end
            if (ld_illegal_op) resp_illegal_q <= 1'b1;
            if (ld_csr) begin
                resp_rdata_q   <= addr_known ? csr_read_data : '0;
                resp_illegal_q <= !addr_known;
            end
            if (ld_pc) begin
                resp_pc_q       <= csr_read_data;
                resp_redirect_q <= 1'b1;
            end
            if (clr_resp) begin
                resp_rdata_q    <= '0;
                resp_illegal_q  <= 1'b0;
                resp_redirect_q <= 1'b0;
                resp_pc_q       <= '0;
            end
        end
    end

    assign resp_rdata    = resp_rdata_q;
    assign resp_illegal  = resp_illegal_q;
    assign resp_redirect = resp_redirect_q;
    assign resp_pc       = resp_pc_q;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Testbench for csr_trap_ctrl: models the external CSR file and predicts each
// transaction's response, latency, write count and resulting CSR contents.
module tb_csr_trap_ctrl;

    localparam int DW = 64;
    localparam int AW = 12;

    logic          clk, rst;
    logic          req_valid, req_ready;
    logic [2:0]    req_op;
    logic [AW-1:0] req_csr_addr;
    logic [DW-1:0] req_src;
    logic          req_src_is_x0;
    logic [DW-1:0] req_pc;
    logic          resp_valid, resp_ready;
    logic [DW-1:0] resp_rdata;
    logic          resp_illegal, resp_redirect;
    logic [DW-1:0] resp_pc;
    logic [1:0]    csr_read_idx;
    logic [DW-1:0] csr_read_data;
    logic          csr_write_en;
    logic [1:0]    csr_write_idx;
    logic [DW-1:0] csr_write_data;

    csr_trap_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_csr_addr(req_csr_addr), .req_src(req_src),
        .req_src_is_x0(req_src_is_x0), .req_pc(req_pc),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_illegal(resp_illegal),
        .resp_redirect(resp_redirect), .resp_pc(resp_pc),
        .csr_read_idx(csr_read_idx), .csr_read_data(csr_read_data),
        .csr_write_en(csr_write_en), .csr_write_idx(csr_write_idx),
        .csr_write_data(csr_write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External CSR file: combinational read, write at the clock edge.
    logic [DW-1:0] csr_file [4];
    logic          file_clr;
    int unsigned   write_cnt;

    assign csr_read_data = csr_file[csr_read_idx];

    always @(posedge clk) begin
        if (file_clr) begin
            for (int i = 0; i < 4; i++) csr_file[i] <= '0;
            write_cnt <= 0;
        end else if (csr_write_en) begin
            csr_file[csr_write_idx] <= csr_write_data;
            write_cnt <= write_cnt + 1;
        end
    end

    // Reference model of the CSR file contents.
    logic [DW-1:0] m_csr [4];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int csr_index(input logic [AW-1:0] a);
        case (a)
            12'h300: return 0;
            12'h305: return 1;
            12'h341: return 2;
            12'h342: return 3;
            default: return -1;
        endcase
    endfunction

    function automatic logic [DW-1:0] ecall_status(input logic [DW-1:0] s);
        logic [DW-1:0] r;
        r        = s;
        r[7]     = s[3];
        r[3]     = 1'b0;
        r[12:11] = 2'b11;
        return r;
    endfunction

    function automatic logic [DW-1:0] mret_status(input logic [DW-1:0] s);
        logic [DW-1:0] r;
        r        = s;
        r[3]     = s[7];
        r[7]     = 1'b1;
        r[12:11] = 2'b00;
        return r;
    endfunction

    task automatic check_file(input string tag);
        for (int i = 0; i < 4; i++)
            check($sformatf("%s csr[%0d]", tag, i), csr_file[i], m_csr[i]);
    endtask

    // Issue one request (called at posedge+1), predict, wait, hold, release.
    task automatic do_req(input logic [2:0] op, input logic [AW-1:0] addr,
                          input logic [DW-1:0] src, input logic x0,
                          input logic [DW-1:0] pc, input int hold, input bit intrude);
        logic [DW-1:0] e_rdata, e_pc, old;
        logic          e_ill, e_redir;
        int            e_lat, e_wr, idx, edges;
        int unsigned   start;
        e_rdata = '0; e_pc = '0; e_ill = 1'b0; e_redir = 1'b0; e_wr = 0; e_lat = 1;
        case (op)
            3'd0, 3'd1, 3'd2: begin
                e_lat = 2;
                idx   = csr_index(addr);
                if (idx < 0) e_ill = 1'b1;
                else begin
                    old     = m_csr[idx];
                    e_rdata = old;
                    if (op == 3'd0 || !x0) begin
                        e_wr = 1;
                        if (op == 3'd0)      m_csr[idx] = src;
                        else if (op == 3'd1) m_csr[idx] = old | src;
                        else                 m_csr[idx] = old & ~src;
                    end
                end
            end
            3'd3: begin
                e_pc     = m_csr[1];
                e_redir  = 1'b1;
                m_csr[2] = pc;
                m_csr[3] = 64'd11;
                e_wr     = 2;
                e_lat    = 3;
`ifdef CSR_TRAP_CTRL_MSTATUS_EN
                m_csr[0] = ecall_status(m_csr[0]);
                e_wr     = 3;
                e_lat    = 4;
`endif
            end
            3'd4: begin
                e_pc    = m_csr[2];
                e_redir = 1'b1;
                e_lat   = 2;
`ifdef CSR_TRAP_CTRL_MSTATUS_EN
                m_csr[0] = mret_status(m_csr[0]);
                e_wr     = 1;
                e_lat    = 3;
`endif
            end
            default: e_ill = 1'b1;
        endcase

        check("req_ready before accept", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_op = op; req_csr_addr = addr;
        req_src = src; req_src_is_x0 = x0; req_pc = pc;
        start = write_cnt;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_op = 3'($urandom); req_csr_addr = AW'($urandom);
        req_src = {$urandom, $urandom}; req_pc = {$urandom, $urandom};
        edges = 1;
        while (!resp_valid && edges < 16) begin
            @(posedge clk); #1;
            edges++;
        end
        check($sformatf("latency op%0d", op), 64'(edges), 64'(e_lat));
        check("resp_rdata", resp_rdata, e_rdata);
        check("resp_illegal", 64'(resp_illegal), 64'(e_ill));
        check("resp_redirect", 64'(resp_redirect), 64'(e_redir));
        check("resp_pc", resp_pc, e_pc);
        check("req_ready busy", 64'(req_ready), 64'd0);

        for (int h = 0; h < hold; h++) begin
            if (intrude) begin
                req_valid = 1'b1; req_op = 3'd3; req_pc = 64'hdead_0000;
            end
            @(posedge clk); #1;
            check("hold resp_valid", 64'(resp_valid), 64'd1);
            check("hold resp_rdata", resp_rdata, e_rdata);
            check("hold resp_pc", resp_pc, e_pc);
            check("hold resp_illegal", 64'(resp_illegal), 64'(e_ill));
            check("hold req_ready", 64'(req_ready), 64'd0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("resp_valid after take", 64'(resp_valid), 64'd0);
        check("rdata cleared", resp_rdata, 64'd0);
        check("illegal cleared", 64'(resp_illegal), 64'd0);
        check("redirect cleared", 64'(resp_redirect), 64'd0);
        check("pc cleared", resp_pc, 64'd0);
        check("req_ready after take", 64'(req_ready), 64'd1);
        check($sformatf("write count op%0d", op), 64'(write_cnt - start), 64'(e_wr));
        check_file("after req");
    endtask

    logic [AW-1:0] addr_tab [4];

    initial begin
        int unsigned start;
        int          r;
        logic [2:0]  op;
        logic [AW-1:0] addr;

        addr_tab[0] = 12'h300; addr_tab[1] = 12'h305;
        addr_tab[2] = 12'h341; addr_tab[3] = 12'h342;
        for (int i = 0; i < 4; i++) m_csr[i] = '0;

        rst = 1'b1; file_clr = 1'b1;
        req_valid = 1'b0; req_op = '0; req_csr_addr = '0; req_src = '0;
        req_src_is_x0 = 1'b0; req_pc = '0; resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; file_clr = 1'b0;
        @(posedge clk); #1;

        check("reset req_ready", 64'(req_ready), 64'd1);
        check("reset resp_valid", 64'(resp_valid), 64'd0);
        check("reset write_en", 64'(csr_write_en), 64'd0);
        check("reset read_idx", 64'(csr_read_idx), 64'd0);
        check("reset rdata", resp_rdata, 64'd0);
        check("reset redirect", 64'(resp_redirect), 64'd0);

        // Directed scenarios.
        do_req(3'd0, 12'h305, 64'h8000_0000, 1'b0, 64'h0, 0, 1'b0);
        do_req(3'd0, 12'h300, 64'h1800, 1'b0, 64'h0, 0, 1'b0);
        do_req(3'd1, 12'h300, 64'h8, 1'b0, 64'h0, 0, 1'b0);
        do_req(3'd1, 12'h300, 64'h8, 1'b1, 64'h0, 0, 1'b0);
        do_req(3'd0, 12'h305, 64'h8000_0100, 1'b0, 64'h0, 0, 1'b0);
        do_req(3'd0, 12'h300, 64'h8, 1'b0, 64'h0, 0, 1'b0);
        do_req(3'd3, 12'h000, 64'h0, 1'b0, 64'h8000_0040, 0, 1'b0);
        do_req(3'd0, 12'h341, 64'h8000_0044, 1'b0, 64'h0, 0, 1'b0);
        do_req(3'd4, 12'h000, 64'h0, 1'b0, 64'h0, 0, 1'b0);
        do_req(3'd2, 12'h342, 64'h3, 1'b0, 64'h0, 0, 1'b0);
        do_req(3'd0, 12'h7C0, 64'h1234, 1'b0, 64'h0, 0, 1'b0);
        do_req(3'd6, 12'h300, 64'h1234, 1'b0, 64'h0, 0, 1'b0);
        do_req(3'd1, 12'h305, 64'hF, 1'b0, 64'h0, 5, 1'b1);

        // Reset asserted while the trap sits in its first write cycle.
        check("req_ready pre-trap", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_op = 3'd3; req_pc = 64'h8000_0abc;
        start = write_cnt;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("epc write_en", 64'(csr_write_en), 64'd1);
        rst = 1'b1;
        #1;
        check("rst write_en", 64'(csr_write_en), 64'd0);
        check("rst req_ready", 64'(req_ready), 64'd1);
        check("rst resp_valid", 64'(resp_valid), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst no writes", 64'(write_cnt - start), 64'd0);
        check("rst idle", 64'(req_ready), 64'd1);
        check_file("after rst");

        // Randomised traffic.
        for (int t = 0; t < 60; t++) begin
            r = $urandom_range(0, 9);
            addr = addr_tab[$urandom_range(0, 3)];
            if (r <= 5) op = 3'(r % 3);
            else if (r == 6) op = 3'd3;
            else if (r == 7) op = 3'd4;
            else if (r == 8) op = 3'(5 + $urandom_range(0, 2));
            else begin
                op = 3'($urandom_range(0, 2));
                addr = AW'($urandom);
            end
            do_req(op, addr, {$urandom, $urandom}, 1'($urandom),
                   {$urandom, $urandom}, $urandom_range(0, 2), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
